// File: rtl/motor_pkg.sv
// motor_pkg: command encodings, FSM states, coil phase tables and axis limits
// shared by the stepper axis drivers.
package motor_pkg;

    localparam logic [1:0] CMD_MOVE = 2'b01;
    localparam logic [1:0] CMD_STOP = 2'b00;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DWELL = 2'd2} state_e;

    // Phase n occupies bits [4n+3:4n].
    localparam logic [15:0] FULL_TAB = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [31:0] HALF_TAB = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

    localparam logic [15:0] THETA_POS_MAX = 16'd180;
    localparam logic [15:0] PHI_POS_MAX   = 16'd359;

endpackage

// File: rtl/stepper_axis_driver_if.sv
// stepper_axis_driver_if: controller-side commands and power-stage outputs of one axis.
interface stepper_axis_driver_if;

    logic [1:0]  cmd_pos;
    logic [1:0]  cmd_neg;
    logic        pos_load;
    logic [15:0] pos_load_val;
    logic        step;
    logic        dir;
    logic [3:0]  coil;
    logic [15:0] pos_actual;
    logic        busy;
    logic        fault;
    logic        at_limit;

    modport master (
        output cmd_pos, cmd_neg, pos_load, pos_load_val,
        input  step, dir, coil, pos_actual, busy, fault, at_limit
    );

    modport slave (
        input  cmd_pos, cmd_neg, pos_load, pos_load_val,
        output step, dir, coil, pos_actual, busy, fault, at_limit
    );

endinterface

// File: rtl/step_phase_gen.sv
// step_phase_gen: coil phase index and lookup, advanced one phase per accepted step.
// STEPPER_HALF_STEP_EN selects the 8-phase half-step table.
module step_phase_gen
    import motor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    input  logic       dir_i,
    output logic [3:0] coil_o,
    output logic       pos_tick_o
);

`ifdef STEPPER_HALF_STEP_EN
    localparam int          IW  = 3;
    localparam logic [31:0] TAB = HALF_TAB;
`else
    localparam int          IW  = 2;
    localparam logic [31:0] TAB = {16'h0000, FULL_TAB};
`endif

    logic [IW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else if (adv_i) idx_q <= dir_i ? idx_q + 1'b1 : idx_q - 1'b1;
    end

    assign coil_o = TAB[{idx_q, 2'b00} +: 4];
    // Half-step moves count position only when landing on an odd phase.
    assign pos_tick_o = (IW == 2) || !idx_q[0];

endmodule

// File: rtl/stepper_axis_driver.sv
// stepper_axis_driver: paces step pulses from pos/neg commands and integrates axis position.
// Define STEPPER_HALF_STEP_EN for 8-phase half-step drive at twice the step rate.
module stepper_axis_driver
    import motor_pkg::*;
#(
    parameter int          STEP_DIV  = 4096,
    parameter int          PULSE_W   = 16,
    parameter int          DWELL_CYC = 2048,
    parameter logic [15:0] POS_MAX   = PHI_POS_MAX,
    parameter bit          WRAP      = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    stepper_axis_driver_if.slave bus
);

`ifdef STEPPER_HALF_STEP_EN
    localparam int PERIOD = STEP_DIV / 2;
`else
    localparam int PERIOD = STEP_DIV;
`endif
    localparam int CNT_MAX = STEP_DIV > DWELL_CYC ? STEP_DIV : DWELL_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] PW         = CW'(PULSE_W);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DWELL = DWELL;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic [15:0]   pos_q, pos_d;
    logic          fault_q, at_limit_q;
    logic          req_p, req_n, fwd, rev;
    logic          issue, blocked, adv, pos_tick;

    assign req_p = bus.cmd_pos == CMD_MOVE && bus.cmd_neg != CMD_MOVE;
    assign req_n = bus.cmd_neg == CMD_MOVE && bus.cmd_pos != CMD_MOVE;
    assign fwd   = dir_q ? req_p : req_n;
    assign rev   = dir_q ? req_n : req_p;

    // The divider doubles as the dwell counter; the two never run together.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dir_d   = dir_q;
        issue   = 1'b0;
        if (state_q == ST_IDLE) begin
            state_d = fwd ? ST_RUN : rev ? ST_DWELL : ST_IDLE;
            div_d   = '0;
            dir_d   = rev ? ~dir_q : dir_q;
            issue   = fwd;
        end else if (state_q == ST_RUN) begin
            state_d = fwd ? ST_RUN : rev ? ST_DWELL : ST_IDLE;
            div_d   = fwd && div_q != DIV_LAST ? div_q + 1'b1 : '0;
            dir_d   = rev ? ~dir_q : dir_q;
            issue   = fwd && div_q == DIV_LAST;
        end else begin
            state_d = div_q != DWELL_LAST ? ST_DWELL : fwd ? ST_RUN : ST_IDLE;
            div_d   = div_q != DWELL_LAST ? div_q + 1'b1 : '0;
            issue   = div_q == DWELL_LAST && fwd;
        end
    end

    assign blocked = !WRAP && pos_tick && (dir_q ? pos_q == POS_MAX : pos_q == 16'd0);
    assign adv     = issue && !blocked;
    // A suppressed step leaves step low for its whole pulse window.
    assign step_d  = state_d == ST_RUN && div_d < PW && (div_d == '0 ? adv : step_q);

    always_comb begin
        pos_d = pos_q;
        if (adv && pos_tick)
            pos_d = dir_q ? (pos_q == POS_MAX ? 16'd0 : pos_q + 16'd1)
                          : (pos_q == 16'd0 ? POS_MAX : pos_q - 16'd1);
        if (bus.pos_load)
            pos_d = bus.pos_load_val > POS_MAX ? POS_MAX : bus.pos_load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            pos_q      <= 16'd0;
            fault_q    <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            fault_q    <= bus.cmd_pos == CMD_MOVE && bus.cmd_neg == CMD_MOVE;
            at_limit_q <= !WRAP && ((req_p && pos_q == POS_MAX) || (req_n && pos_q == 16'd0));
        end
    end

    step_phase_gen u_phase (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (adv),
        .dir_i      (dir_q),
        .coil_o     (bus.coil),
        .pos_tick_o (pos_tick)
    );

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.pos_actual = pos_q;
    assign bus.busy       = state_q != ST_IDLE;
    assign bus.fault      = fault_q;
    assign bus.at_limit   = at_limit_q;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// tb_stepper_axis_driver: a modular (A) and a saturating (B) axis share one stimulus
// stream; directed vectors, corner sequences and random traffic against a reference model.
module tb_stepper_axis_driver;
    import motor_pkg::*;

    localparam int SD = 4;
    localparam int DW = 3;
    localparam int PM = 359;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd_pos = CMD_STOP;
    logic [1:0]  cmd_neg = CMD_STOP;
    logic        pos_load = 1'b0;
    logic [15:0] pos_load_val = 16'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    stepper_axis_driver_if ifa();
    stepper_axis_driver_if ifb();

    assign ifa.cmd_pos = cmd_pos;
    assign ifa.cmd_neg = cmd_neg;
    assign ifa.pos_load = pos_load;
    assign ifa.pos_load_val = pos_load_val;
    assign ifb.cmd_pos = cmd_pos;
    assign ifb.cmd_neg = cmd_neg;
    assign ifb.pos_load = pos_load;
    assign ifb.pos_load_val = pos_load_val;

    stepper_axis_driver #(.STEP_DIV(SD), .PULSE_W(1), .DWELL_CYC(DW), .POS_MAX(16'(PM)), .WRAP(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    stepper_axis_driver #(.STEP_DIV(SD), .PULSE_W(2), .DWELL_CYC(DW), .POS_MAX(16'(PM)), .WRAP(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model: what the axis is doing, expressed as countdowns.
    typedef struct {
        bit dir;
        int pos;
        int phase;
        bit running;
        int dwell;
        int tick;
        bit step;
        bit fault;
        bit lim;
    } m_t;

    m_t ma, mb;

    function automatic m_t m_init();
        m_t s;
        s.dir = 1; s.pos = 0; s.phase = 0; s.running = 0; s.dwell = 0;
        s.tick = 0; s.step = 0; s.fault = 0; s.lim = 0;
        return s;
    endfunction

    function automatic m_t model(m_t s, int pw, bit wrap);
        int want;
        bit stepnow, ok;
        want = (cmd_pos == CMD_MOVE && cmd_neg != CMD_MOVE) ? 1 :
               (cmd_neg == CMD_MOVE && cmd_pos != CMD_MOVE) ? 0 : -1;
        s.fault = cmd_pos == CMD_MOVE && cmd_neg == CMD_MOVE;
        s.lim = !wrap && ((want == 1 && s.pos == PM) || (want == 0 && s.pos == 0));
        stepnow = 0;
        if (s.dwell > 0) begin
            s.dwell--;
            if (s.dwell == 0) begin
                s.running = want == int'(s.dir);
                stepnow = s.running;
                s.tick = 0;
            end
        end else if (want < 0) begin
            s.running = 0;
        end else if (want != int'(s.dir)) begin
            s.dir = want == 1;
            s.dwell = DW;
            s.running = 0;
        end else if (!s.running) begin
            s.running = 1;
            s.tick = 0;
            stepnow = 1;
        end else begin
            s.tick = (s.tick + 1) % SD;
            stepnow = s.tick == 0;
        end
        ok = wrap || (s.dir ? s.pos < PM : s.pos > 0);
        if (stepnow && ok) begin
            s.phase = (s.phase + (s.dir ? 1 : 3)) % 4;
            s.pos = (s.pos + (s.dir ? 1 : PM)) % (PM + 1);
        end
        s.step = stepnow ? ok : (s.running && s.tick < pw && s.step);
        if (pos_load) s.pos = int'(pos_load_val) > PM ? PM : int'(pos_load_val);
        return s;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(string t, logic st, logic dr, logic [3:0] co, logic [15:0] pos,
                           logic bz, logic ft, logic lm, m_t m);
        check({t, ".step"}, int'(st), int'(m.step));
        check({t, ".dir"}, int'(dr), int'(m.dir));
        check({t, ".coil"}, int'(co), 1 << m.phase);
        check({t, ".pos"}, int'(pos), m.pos);
        check({t, ".busy"}, int'(bz), int'(m.running || m.dwell > 0));
        check({t, ".fault"}, int'(ft), int'(m.fault));
        check({t, ".at_limit"}, int'(lm), int'(m.lim));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            ma = m_init();
            mb = m_init();
        end else begin
            ma = model(ma, 1, 1'b1);
            mb = model(mb, 2, 1'b0);
        end
        #1;
        cmp_dut("A", ifa.step, ifa.dir, ifa.coil, ifa.pos_actual, ifa.busy, ifa.fault, ifa.at_limit, ma);
        cmp_dut("B", ifb.step, ifb.dir, ifb.coil, ifb.pos_actual, ifb.busy, ifb.fault, ifb.at_limit, mb);
    endtask

    typedef struct {
        logic [1:0]  cp;
        logic [1:0]  cn;
        logic        ld;
        logic [15:0] val;
        logic        st;
        logic        dr;
        logic [3:0]  co;
        int          pos;
        logic        bz;
        logic        ft;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] cp, logic [1:0] cn, logic ld, logic [15:0] val,
                                logic st, logic dr, logic [3:0] co, int pos, logic bz, logic ft);
        vec_t v;
        v.cp = cp; v.cn = cn; v.ld = ld; v.val = val; v.st = st;
        v.dr = dr; v.co = co; v.pos = pos; v.bz = bz; v.ft = ft;
        return v;
    endfunction

    initial begin
        // Scenario 1: twelve cycles of positive motion, three paced steps, then stop.
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(2'b01, 2'b00, 0, 0, i % 4 == 0, 1, 4'(1 << (i / 4 + 1)), i / 4 + 1, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        // Scenario 3: conflicting commands.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(2'b01, 2'b01, 0, 0, 0, 1, 4'b1000, 3, 0, 1));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        // Scenario 6: non-move encodings.
        tbl.push_back(mk(2'b10, 2'b00, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(2'b00, 2'b10, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(2'b00, 2'b11, 0, 0, 0, 1, 4'b1000, 3, 0, 0));
        // Scenario 2: load, wrap forward, reverse through the dwell, wrap back.
        tbl.push_back(mk(2'b00, 2'b00, 1, 16'd359, 0, 1, 4'b1000, 359, 0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 0, 0, 1, 1, 4'b0001, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(2'b00, 2'b01, 0, 0, 1, 0, 4'b1000, 359, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 16'd5000, 0, 0, 4'b1000, 359, 0, 0));

        rst = 1'b1;
        cycle();
        cycle();
        check("reset.step", int'(ifa.step), 0);
        check("reset.dir", int'(ifa.dir), 1);
        check("reset.coil", int'(ifa.coil), 1);
        check("reset.pos", int'(ifa.pos_actual), 0);
        check("reset.busy", int'(ifa.busy), 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_pos = tbl[i].cp;
            cmd_neg = tbl[i].cn;
            pos_load = tbl[i].ld;
            pos_load_val = tbl[i].val;
            cycle();
            check($sformatf("vec%0d.step", i), int'(ifa.step), int'(tbl[i].st));
            check($sformatf("vec%0d.dir", i), int'(ifa.dir), int'(tbl[i].dr));
            check($sformatf("vec%0d.coil", i), int'(ifa.coil), int'(tbl[i].co));
            check($sformatf("vec%0d.pos", i), int'(ifa.pos_actual), tbl[i].pos);
            check($sformatf("vec%0d.busy", i), int'(ifa.busy), int'(tbl[i].bz));
            check($sformatf("vec%0d.fault", i), int'(ifa.fault), int'(tbl[i].ft));
        end
        pos_load = 1'b0;
        cmd_pos = CMD_STOP;
        cmd_neg = CMD_STOP;

        // Scenario 4: saturating axis blocked at the top limit, then backs off.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        pos_load = 1'b1;
        pos_load_val = 16'd359;
        cycle();
        pos_load = 1'b0;
        cmd_pos = CMD_MOVE;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("lim.step", int'(ifb.step), 0);
            check("lim.coil", int'(ifb.coil), 1);
            check("lim.pos", int'(ifb.pos_actual), 359);
            check("lim.at_limit", int'(ifb.at_limit), 1);
        end
        cmd_pos = CMD_STOP;
        cmd_neg = CMD_MOVE;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("back.dwell_step", int'(ifb.step), 0);
            check("back.dir", int'(ifb.dir), 0);
        end
        cycle();
        check("back.step", int'(ifb.step), 1);
        check("back.pos", int'(ifb.pos_actual), 358);
        check("back.at_limit", int'(ifb.at_limit), 0);
        cmd_neg = CMD_STOP;
        cycle();
        check("drop.step", int'(ifb.step), 0);
        check("drop.pos", int'(ifb.pos_actual), 358);

        // Scenario 5: reset two cycles after a step.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cmd_pos = CMD_MOVE;
        for (int i = 0; i < 3; i++) cycle();
        check("prerst.busy", int'(ifa.busy), 1);
        check("prerst.pos", int'(ifa.pos_actual), 1);
        rst = 1'b1;
        cycle();
        check("rst.step", int'(ifa.step), 0);
        check("rst.coil", int'(ifa.coil), 1);
        check("rst.pos", int'(ifa.pos_actual), 0);
        check("rst.busy", int'(ifa.busy), 0);
        rst = 1'b0;
        cmd_pos = CMD_STOP;

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: begin cmd_pos = 2'b00; cmd_neg = 2'b00; end
                    1: begin cmd_pos = 2'b01; cmd_neg = 2'b00; end
                    2: begin cmd_pos = 2'b00; cmd_neg = 2'b01; end
                    3: begin cmd_pos = 2'b01; cmd_neg = 2'b01; end
                    4: begin cmd_pos = 2'b10; cmd_neg = 2'b11; end
                    default: begin cmd_pos = 2'b11; cmd_neg = 2'b01; end
                endcase
            end
            pos_load = $urandom_range(0, 40) == 0;
            pos_load_val = 16'($urandom_range(0, 400));
            rst = $urandom_range(0, 300) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stepper_axis_driver.md
# stepper_axis_driver

- One instance per axis (theta, phi); sits between the tracking controller and the stepper power stage.
- Consumes the controller's registered pos/neg direction commands and produces paced step pulses, direction, and a full-step coil phase pattern.
- Integrates the steps into the 16-bit axis position that the controller reads back as `theta_actual` / `phi_actual`.

## Interface
Parameters:
- `STEP_DIV`, 4096: clock cycles per step period, ≥ 4.
- `PULSE_W`, 16: cycles `step` stays high each period, 1 ≤ `PULSE_W` < `STEP_DIV`.
- `DWELL_CYC`, 2048: idle cycles forced on direction reversal, ≥ 1.
- `POS_MAX`, 359: highest position value.
- `WRAP`, 1: 1 = modular axis (phi), 0 = saturating axis (theta).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_pos` in 2: 2'b01 = move positive (clockwise); any other value = no request.
- `cmd_neg` in 2: 2'b01 = move negative (anticlockwise); any other value = no request.
- `pos_load` in 1: one-cycle strobe to overwrite the position.
- `pos_load_val` in 16: calibration value; values above `POS_MAX` are clamped to `POS_MAX`.
- `step` out 1: step pulse to the power stage.
- `dir` out 1: 1 = positive, 0 = negative.
- `coil` out 4: one-hot full-step phase pattern.
- `pos_actual` out 16: current axis position.
- `busy` out 1: high in RUN or DWELL.
- `fault` out 1: high while both commands are 2'b01.
- `at_limit` out 1: saturating axis only; high while a move is requested but blocked at a limit.

## Operation
- Reset values: state IDLE, `step`=0, `dir`=1, `coil`=4'b0001, `pos_actual`=0, `busy`=0, `fault`=0, `at_limit`=0; divider=0.
- Request decode each cycle:
  - `req_p` = (`cmd_pos`==2'b01) & ~(`cmd_neg`==2'b01).
  - `req_n` = the mirror of `req_p`.
  - Both 2'b01: `fault`=1, treated as no request.
- IDLE:
  - `req_p` or `req_n`, with direction equal to `dir` → RUN. Divider=0; step issued this edge.
  - Direction opposite to `dir` → DWELL. `dir` updates immediately.
- RUN:
  - Divider counts 0..`STEP_DIV`-1 and wraps to 0.
  - At divider 0 a step is issued: `coil` rotates (positive: 0001→0010→0100→1000→0001; negative: the reverse) and `pos_actual` updates by ±1.
  - `step`=1 while divider < `PULSE_W`.
  - Request drops → IDLE at the next edge. Divider clears. `step` drops at once, even mid-pulse. The step already issued stands.
  - Request reverses → DWELL. `dir` flips.
- DWELL: counts `DWELL_CYC` cycles with no steps, then → RUN if the request in the new direction persists, else → IDLE.
- Position arithmetic, 16-bit unsigned:
  - `WRAP`=1: `POS_MAX`+1 wraps to 0; decrementing from 0 gives `POS_MAX`.
  - `WRAP`=0: a step that would pass 0 or `POS_MAX` is suppressed. No coil change, no pulse, `at_limit`=1.
- `pos_load` has priority over a same-cycle step update. The coil still advances if that step is issued.
- `pos_load` is accepted in any state.

## Timing
- Request sampled at edge k → first `step` high, `coil` and `pos_actual` updated after edge k.
- Step rate: one step per `STEP_DIV` cycles.
- Reversal latency: `DWELL_CYC`+1 cycles from the reversed request to the first step in the new direction.
- `fault` and `at_limit` are registered: 1-cycle latency.
- Reset mid-RUN or mid-DWELL: all outputs return to reset values at that edge. The position is lost.

## Configuration
- `STEPPER_HALF_STEP_EN` defined:
  - `coil` uses an 8-phase half-step sequence: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Steps are issued every `STEP_DIV`/2 cycles.
  - `pos_actual` changes only when entering an odd-index phase (0011, 0110, 1100, 1001), i.e. every two half-steps, so position units match full-step mode.
- Not defined: 4-phase full-step behaviour as above.

## Structure
- Shared package `motor_pkg` holds:
  - the command encodings `CMD_MOVE`=2'b01 and `CMD_STOP`=2'b00;
  - the state enum IDLE/RUN/DWELL;
  - the coil phase tables;
  - default `POS_MAX` constants for theta and phi.
- One natural sub-module, `step_phase_gen`: holds the phase index register and the coil lookup, advanced by step/dir.
- Divider, FSM and position accumulator stay in the top block.

## Test plan
All scenarios use `STEP_DIV`=4, `PULSE_W`=1, `DWELL_CYC`=3, `POS_MAX`=359, `WRAP`=1.

1. `cmd_pos`=01 for 12 cycles from `pos_actual`=0:
   - 3 step pulses, 4 cycles apart;
   - `pos_actual` 0→1→2→3;
   - `coil` 0001→0010→0100→1000;
   - then IDLE with `busy`=0.
2. `pos_load`=1 with value 359, then `cmd_pos`=01 for one step → `pos_actual`=0. Then `cmd_neg`=01:
   - `dir`=0 at once;
   - 3 DWELL cycles with no step;
   - step on the 4th cycle;
   - `pos_actual`=359.
3. Both commands 01 for 5 cycles → `fault`=1 from cycle 2, no steps, `pos_actual` unchanged.
4. `WRAP`=0 at `pos_actual`=359 with `cmd_pos`=01 → no pulse, `coil` unchanged, `at_limit`=1. `cmd_neg`=01 after the dwell → `pos_actual`=358.
5. Assert `rst` during RUN, 2 cycles after a step → next cycle: `step`=0, `coil`=0001, `pos_actual`=0, `busy`=0.
6. `cmd_pos`=10 or 11 → treated as stop: no steps, `fault`=0.
